spartan_reduce_n: RTL and testbench
===================================

Name: spartan_reduce_n

Overview:
- Parametrised N:1 bus width reducer for the spartan testbench fabric.
- Accepts one wide word of RATIO*OUTPUT_WIDTH bits and emits it as up to RATIO narrow beats over a valid/ready stream.
- Adds three things over a plain 2:1 reducer: a registered holding stage, partial-word beat count with a last-beat flag, and selectable beat order.
- Sits between wide producers (memory read paths, DMA) and narrow consumers (UART/debug buses).

Parameters:
- OUTPUT_WIDTH, 32, width of one output beat in bits (>=1).
- RATIO, 4, narrow beats per full input word (2..16).
- CNT_W, 2, width of DIN_CNT and the internal beat counter; 2**CNT_W >= RATIO is required.
- MSB_FIRST, 0, 0 = least-significant slice emitted first; 1 = most-significant slice first.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  synchronous, active-high reset.
- DIN  input  RATIO*OUTPUT_WIDTH  wide input word.
- DIN_CNT  input  CNT_W  valid beats in DIN minus one (0 = 1 beat).
- DIN_VAL  input  1  DIN/DIN_CNT valid.
- DIN_RDY  output  1  block can accept DIN this cycle.
- DOUT  output  OUTPUT_WIDTH  current beat.
- DOUT_LAST  output  1  current beat is the final beat of its word.
- DOUT_VAL  output  1  DOUT/DOUT_LAST valid.
- DOUT_RDY  input  1  consumer accepts beat this cycle.

Behaviour:

Reset:
- On a CLK edge with RST=1, the holding register is cleared to empty, the beat counter goes to 0 and the stored count goes to 0.
- Outputs following reset: DOUT_VAL=0, DOUT_LAST=0, DOUT=0, DIN_RDY=1.
- Reset mid-word discards the remaining beats; nothing is emitted for that word afterwards.

State:
- Two states: EMPTY and HOLD.
- Holding register: word, last index L = min(DIN_CNT, RATIO-1), beat index B.

Transfers:
- Input accept when DIN_VAL && DIN_RDY.
- Output transfer when DOUT_VAL && DOUT_RDY.

DIN_RDY:
- DIN_RDY = EMPTY || (DOUT_RDY && B==L).
- It is combinational from DOUT_RDY and the state; it never depends on DIN_VAL.

EMPTY state:
- On input accept: capture the word, set L, set B=0, go to HOLD.
- DOUT_VAL is 0 in EMPTY.

HOLD state:
- DOUT_VAL=1.
- DOUT = slice B of the held word when MSB_FIRST=0, or slice (RATIO-1-B) when MSB_FIRST=1.
- Slice k is bits [(k+1)*OUTPUT_WIDTH-1 : k*OUTPUT_WIDTH].
- DOUT_LAST = (B==L).
- Output transfer with B<L: B increments.
- Output transfer with B==L and input accept in the same cycle: reload the new word, B=0, stay in HOLD. There is no bubble.
- Output transfer with B==L and no input accept: go to EMPTY.

Latency and throughput:
- First beat appears one cycle after input accept.
- Sustained throughput is one beat per cycle with DOUT_RDY held high, including across word boundaries.

Stability:
- While DOUT_VAL && !DOUT_RDY, DOUT and DOUT_LAST hold constant.
- The held word is unaffected by DIN changes.

Out-of-range counts:
- DIN_CNT > RATIO-1 is clamped to RATIO-1 at capture.
- Unused upper slices of a partial word are never emitted.

Idle cycles:
- DIN_VAL=0 in EMPTY leaves all state unchanged.
- DOUT_RDY=0 in HOLD leaves all state unchanged.

Test Plan:
- Order: RATIO=4, OUTPUT_WIDTH=8, MSB_FIRST=0, DIN=0x44332211, DIN_CNT=3, DOUT_RDY=1 -> beats 0x11,0x22,0x33,0x44 on consecutive cycles starting 1 cycle after accept; DOUT_LAST only on 0x44; DIN_RDY=1 only in the 0x44 cycle.
- Back-to-back: two words 0x44332211 then 0x88776655 offered continuously -> 8 beats on 8 consecutive cycles with no DOUT_VAL gap; second accept coincides with the 0x44 transfer.
- Backpressure: DOUT_RDY toggles 1,0,0,1,0,1,1 -> DOUT held constant while stalled; beat sequence unchanged; DIN_RDY=0 during stall on last beat.
- Partial/clamp: DIN_CNT=1 -> beats 0x11,0x22 with LAST on 0x22. With RATIO=3 and DIN_CNT=3 -> clamped to 3 beats.
- MSB_FIRST=1: same 0x44332211, DIN_CNT=3 -> beats 0x44,0x33,0x22,0x11. DIN_CNT=0 -> single beat 0x44 with LAST.
- Reset mid-word: assert RST after beat 0x22 -> next cycle DOUT_VAL=0, DIN_RDY=1; a fresh word 0xDDCCBBAA is then emitted from 0xAA with no leftover 0x33/0x44.

Source files
------------

// File: rtl/spartan_reduce_n.sv
// spartan_reduce_n: N:1 bus width reducer with holding stage,
// partial-word beat count, last-beat flag and selectable beat order.
module spartan_reduce_n #(
   parameter int OUTPUT_WIDTH = 32,
   parameter int RATIO        = 4,
   parameter int CNT_W        = 2,
   parameter bit MSB_FIRST    = 1'b0
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [RATIO*OUTPUT_WIDTH-1:0]   DIN,
   input  logic [CNT_W-1:0]                DIN_CNT,
   input  logic                            DIN_VAL,
   output logic                            DIN_RDY,
   output logic [OUTPUT_WIDTH-1:0]         DOUT,
   output logic                            DOUT_LAST,
   output logic                            DOUT_VAL,
   input  logic                            DOUT_RDY
);

   localparam int WW = RATIO * OUTPUT_WIDTH;
   localparam logic [CNT_W-1:0] LAST_MAX = CNT_W'(RATIO - 1);

   typedef enum logic {
      EMPTY,
      HOLD
   } state_t;

   state_t                  state_q, state_d;
   logic [WW-1:0]           word_q, word_d;
   logic [CNT_W-1:0]        last_q, last_d;
   logic [CNT_W-1:0]        beat_q, beat_d;

   logic                    at_last;
   logic                    in_acc;
   logic                    out_xfer;
   logic [CNT_W-1:0]        cnt_clamp;
   logic [CNT_W-1:0]        sel;
   logic [OUTPUT_WIDTH-1:0] dout_mux;

   assign at_last   = (beat_q == last_q);
   assign DOUT_VAL  = (state_q == HOLD);
   assign DIN_RDY   = (state_q == EMPTY) || (DOUT_RDY && at_last);
   assign in_acc    = DIN_VAL && DIN_RDY;
   assign out_xfer  = DOUT_VAL && DOUT_RDY;
   assign cnt_clamp = (DIN_CNT > LAST_MAX) ? LAST_MAX : DIN_CNT;
   assign sel       = MSB_FIRST ? (LAST_MAX - beat_q) : beat_q;

   always_comb begin
      dout_mux = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (sel == CNT_W'(k)) begin
            dout_mux = word_q[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
         end
      end
   end

   assign DOUT      = DOUT_VAL ? dout_mux : '0;
   assign DOUT_LAST = DOUT_VAL && at_last;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      last_d  = last_q;
      beat_d  = beat_q;
      unique case (state_q)
         EMPTY: begin
            if (in_acc) begin
               word_d  = DIN;
               last_d  = cnt_clamp;
               beat_d  = '0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_xfer) begin
               if (!at_last) begin
                  beat_d = beat_q + CNT_W'(1);
               end else if (in_acc) begin
                  // reload on the last beat keeps the stream bubble-free
                  word_d = DIN;
                  last_d = cnt_clamp;
                  beat_d = '0;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= EMPTY;
         word_q  <= '0;
         last_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: tb/tb_spartan_reduce_n.sv
// Bench for spartan_reduce_n: directed beats plus random traffic
// scored against a queue-of-beats model, on two parameter sets.
module tb_spartan_reduce_n;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] din_a  [2];
   logic [1:0]  cnt_a  [2];
   logic        val_a  [2];
   logic        ordy_a [2];

   int n_tot = 0;
   int n_bad = 0;

   logic [7:0] e0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] e1 [3] = '{8'h33, 8'h22, 8'h11};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // u[0]: RATIO=4 LSB first; u[1]: RATIO=3 MSB first (clamps DIN_CNT=3)
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int R = (g == 0) ? 4 : 3;
      localparam bit M = (g == 1);

      logic [7:0] dout;
      logic       last, oval, irdy;
      logic [8:0] q[$];
      bit         post_rst = 1'b1;

      spartan_reduce_n #(
         .OUTPUT_WIDTH(8),
         .RATIO(R),
         .CNT_W(2),
         .MSB_FIRST(M)
      ) dut (
         .CLK(clk),
         .RST(rst),
         .DIN(din_a[g][R*8-1:0]),
         .DIN_CNT(cnt_a[g]),
         .DIN_VAL(val_a[g]),
         .DIN_RDY(irdy),
         .DOUT(dout),
         .DOUT_LAST(last),
         .DOUT_VAL(oval),
         .DOUT_RDY(ordy_a[g])
      );

      always @(posedge clk) begin
         bit acc;
         int L;
         logic [31:0] w;
         if (rst) begin
            q.delete();
            post_rst = 1'b1;
         end else begin
            acc = val_a[g] &&
                  (q.size() == 0 || (ordy_a[g] && q.size() == 1));
            if (q.size() != 0 && ordy_a[g]) void'(q.pop_front());
            if (acc) begin
               post_rst = 1'b0;
               w = din_a[g];
               L = (int'(cnt_a[g]) > R - 1) ? R - 1 : int'(cnt_a[g]);
               for (int i = 0; i <= L; i++) begin
                  int idx;
                  idx = M ? (R - 1 - i) : i;
                  q.push_back({(i == L), 8'(w >> (idx * 8))});
               end
            end
         end
      end

      always @(negedge clk) begin
         if (!rst) begin
            chk($sformatf("u%0d.val", g), 32'(oval), 32'(q.size() != 0));
            chk($sformatf("u%0d.rdy", g), 32'(irdy),
                32'(q.size() == 0 || (ordy_a[g] && q.size() == 1)));
            if (q.size() != 0) begin
               chk($sformatf("u%0d.dout", g), 32'(dout), 32'(q[0][7:0]));
               chk($sformatf("u%0d.last", g), 32'(last), 32'(q[0][8]));
            end else if (post_rst) begin
               chk($sformatf("u%0d.rdout", g), 32'(dout), 32'd0);
               chk($sformatf("u%0d.rlast", g), 32'(last), 32'd0);
            end
         end
      end
   end

   initial begin
      for (int g = 0; g < 2; g++) begin
         din_a[g]  = '0;
         cnt_a[g]  = '0;
         val_a[g]  = 1'b0;
         ordy_a[g] = 1'b1;
      end
      repeat (2) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst.val0", 32'(u[0].oval), 32'd0);
      chk("rst.rdy0", 32'(u[0].irdy), 32'd1);
      chk("rst.dout0", 32'(u[0].dout), 32'd0);
      chk("rst.last0", 32'(u[0].last), 32'd0);
      chk("rst.val1", 32'(u[1].oval), 32'd0);
      chk("rst.rdy1", 32'(u[1].irdy), 32'd1);

      for (int g = 0; g < 2; g++) begin
         din_a[g] = 32'h44332211;
         cnt_a[g] = 2'd3;
         val_a[g] = 1'b1;
      end
      step();
      for (int g = 0; g < 2; g++) val_a[g] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ord.dout0", 32'(u[0].dout), 32'(e0[i]));
         chk("ord.last0", 32'(u[0].last), 32'(i == 3));
         chk("ord.rdy0", 32'(u[0].irdy), 32'(i == 3));
         if (i < 3) begin
            chk("msb.dout1", 32'(u[1].dout), 32'(e1[i]));
            chk("msb.last1", 32'(u[1].last), 32'(i == 2));
         end
         step();
      end

      for (int g = 0; g < 2; g++) val_a[g] = 1'b1;
      step();
      for (int g = 0; g < 2; g++) val_a[g] = 1'b0;
      @(negedge clk);
      chk("mid.b0", 32'(u[0].dout), 32'h11);
      step();
      @(negedge clk);
      chk("mid.b1", 32'(u[0].dout), 32'h22);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid.val", 32'(u[0].oval), 32'd0);
      chk("mid.rdy", 32'(u[0].irdy), 32'd1);
      chk("mid.dout", 32'(u[0].dout), 32'd0);
      for (int g = 0; g < 2; g++) begin
         din_a[g] = 32'hDDCCBBAA;
         val_a[g] = 1'b1;
      end
      step();
      for (int g = 0; g < 2; g++) val_a[g] = 1'b0;
      @(negedge clk);
      chk("fresh.dout0", 32'(u[0].dout), 32'hAA);
      chk("fresh.dout1", 32'(u[1].dout), 32'hCC);
      repeat (6) step();

      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int g = 0; g < 2; g++) begin
            val_a[g]  = ($urandom_range(0, 9) < 7);
            din_a[g]  = $urandom;
            cnt_a[g]  = 2'($urandom_range(0, 3));
            ordy_a[g] = ($urandom_range(0, 3) != 0);
         end
         step();
      end

      rst = 1'b0;
      for (int g = 0; g < 2; g++) begin
         val_a[g]  = 1'b0;
         ordy_a[g] = 1'b1;
      end
      repeat (8) step();
      @(negedge clk);
      chk("drain0", 32'(u[0].oval), 32'd0);
      chk("drain1", 32'(u[1].oval), 32'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
